// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared response codes and address helpers for the AXI4-Lite register file
package axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;
  function automatic int addr_lsb(input int dlen);
    return $clog2(dlen / 8);
  endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite signal bundle with slave and master views
interface axi4_lite_if #(
  parameter int ALEN = 32,
  parameter int DLEN = 32
) (
  input logic aclk,
  input logic aresetn
);
  logic [ALEN-1:0]   awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DLEN-1:0]   wdata;
  logic [DLEN/8-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ALEN-1:0]   araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport S (
    input  aclk, aresetn, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport M (
    input  aclk, aresetn, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready
  );
endinterface

// File: rtl/axi4_lite_hold_buf.sv
// axi4_lite_hold_buf: one-entry valid/ready capture buffer, emptied by clear
module axi4_lite_hold_buf #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_clear,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic         r_full;
  logic [W-1:0] r_data;
  assign o_ready = i_en & !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end
endmodule

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave register file with byte strobes, RO slots and write pulses
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int              ALEN    = 32,
  parameter int              DLEN    = 32,
  parameter int              NREG    = 8,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4_lite_if.S               axi,
  output logic [NREG*DLEN-1:0] reg_q,
  input  logic [NREG*DLEN-1:0] reg_hw_d,
  output logic [NREG-1:0]      reg_wr_pulse
);
  localparam int ADDR_LSB = addr_lsb(DLEN);
  localparam int IDXW     = $clog2(NREG);
  localparam int NB       = DLEN / 8;
  function automatic logic dec_err(input logic [ALEN-1:0] a);
    return ((a >> (ADDR_LSB + IDXW)) != '0) || (32'(a[ADDR_LSB +: IDXW]) >= 32'(NREG));
  endfunction
  logic                 r_live;
  logic [NREG*DLEN-1:0] r_q;
  logic [NREG-1:0]      r_pulse;
  logic                 r_bvalid;
  resp_e                r_bresp;
  logic                 r_rvalid;
  resp_e                r_rresp;
  logic [DLEN-1:0]      r_rdata;
  logic                 w_aw_full;
  logic                 w_w_full;
  logic [ALEN-1:0]      w_aw_addr;
  logic [NB+DLEN-1:0]   w_wbuf;
  logic [IDXW-1:0]      w_aw_idx;
  logic                 w_commit;
  logic                 w_wr_ok;
  logic [IDXW-1:0]      w_ar_idx;
  logic                 w_ar_err;
  logic                 w_ar_hs;
  logic [DLEN-1:0]      w_ar_data;
  logic                 w_unused;
  axi4_lite_hold_buf #(.W(ALEN)) u_aw_buf (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_en    (r_live),
    .i_valid (axi.awvalid),
    .o_ready (axi.awready),
    .i_data  (axi.awaddr),
    .i_clear (w_commit),
    .o_full  (w_aw_full),
    .o_data  (w_aw_addr)
  );
  axi4_lite_hold_buf #(.W(NB + DLEN)) u_w_buf (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_en    (r_live),
    .i_valid (axi.wvalid),
    .o_ready (axi.wready),
    .i_data  ({axi.wstrb, axi.wdata}),
    .i_clear (w_commit),
    .o_full  (w_w_full),
    .o_data  (w_wbuf)
  );
  // A new commit may replace a response that is being handshaken this cycle
  assign w_commit  = w_aw_full & w_w_full & (!r_bvalid | axi.bready);
  assign w_aw_idx  = w_aw_addr[ADDR_LSB +: IDXW];
  assign w_wr_ok   = w_commit & !dec_err(w_aw_addr) & !RO_MASK[w_aw_idx];
  assign w_ar_idx  = axi.araddr[ADDR_LSB +: IDXW];
  assign w_ar_err  = dec_err(axi.araddr);
  assign w_ar_hs   = axi.arvalid & axi.arready;
  assign w_ar_data = w_ar_err ? '0 :
                     RO_MASK[w_ar_idx] ? reg_hw_d[w_ar_idx*DLEN +: DLEN] : r_q[w_ar_idx*DLEN +: DLEN];
  assign w_unused  = ^{axi.awprot, axi.arprot, axi.aclk, axi.aresetn};
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_live   <= 1'b0;
      r_q      <= '0;
      r_pulse  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else begin
      r_live  <= 1'b1;
      r_pulse <= w_wr_ok ? NREG'(1) << w_aw_idx : '0;
      for (int i = 0; i < NREG; i++)
        for (int k = 0; k < NB; k++)
          if (w_wr_ok && w_aw_idx == IDXW'(i) && w_wbuf[DLEN+k])
            r_q[i*DLEN + k*8 +: 8] <= w_wbuf[k*8 +: 8];
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? OKAY : SLVERR;
      end else if (axi.bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_ar_err ? SLVERR : OKAY;
        r_rdata  <= w_ar_data;
      end else if (axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
  assign axi.bvalid   = r_bvalid;
  assign axi.bresp    = r_bresp;
  assign axi.arready  = r_live & !r_rvalid;
  assign axi.rvalid   = r_rvalid;
  assign axi.rresp    = r_rresp;
  assign axi.rdata    = r_rdata;
  assign reg_q        = r_q;
  assign reg_wr_pulse = r_pulse;
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// tb_axi4_lite_regfile: scoreboard bench with a register-array reference model
module tb_axi4_lite_regfile;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [255:0] reg_q;
  logic [255:0] reg_hw_d;
  logic [7:0]   reg_wr_pulse;
  int           total = 0;
  int           bad = 0;
  logic         rmode = 1'b0;
  logic [31:0]  m [8];
  logic [1:0]   bq [$];
  logic [33:0]  rq [$];
  int           pidx [$];
  logic [31:0]  pval [$];
  always #5 aclk = ~aclk;
  axi4_lite_if #(.ALEN(32), .DLEN(32)) axi (.aclk(aclk), .aresetn(aresetn));
  axi4_lite_regfile #(.ALEN(32), .DLEN(32), .NREG(8), .RO_MASK(8'h80)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .axi          (axi),
    .reg_q        (reg_q),
    .reg_hw_d     (reg_hw_d),
    .reg_wr_pulse (reg_wr_pulse)
  );
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic flag(input string n);
    total++;
    bad++;
    $display("FAIL %s got=timeout/unexpected exp=event", n);
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  always @(negedge aclk) begin
    if (aresetn) begin
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) flag("b_unexpected");
        else chk("bresp", 64'(axi.bresp), 64'(bq.pop_front()));
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) flag("r_unexpected");
        else begin
          logic [33:0] e;
          e = rq.pop_front();
          chk("rdata", 64'(axi.rdata), 64'(e[31:0]));
          chk("rresp", 64'(axi.rresp), 64'(e[33:32]));
        end
      end
      if (reg_wr_pulse != 8'h00) begin
        if (pidx.size() == 0) flag("pulse_unexpected");
        else begin
          int i;
          logic [31:0] v;
          i = pidx.pop_front();
          v = pval.pop_front();
          chk("pulse", 64'(reg_wr_pulse), 64'(8'(1) << i));
          chk("pulse_reg", 64'(reg_q[i*32 +: 32]), 64'(v));
        end
      end
    end
  end
  initial forever begin
    step();
    if (rmode) begin
      axi.bready = 1'($urandom_range(0, 1));
      axi.rready = 1'($urandom_range(0, 1));
    end
  end
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    axi.awaddr = a;
    axi.awvalid = 1'b1;
    @(negedge aclk);
    while (!axi.awready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) flag("aw_timeout");
    step();
    axi.awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.wdata = d;
    axi.wstrb = s;
    axi.wvalid = 1'b1;
    @(negedge aclk);
    while (!axi.wready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) flag("w_timeout");
    step();
    axi.wvalid = 1'b0;
  endtask
  // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
    int  i = int'((a >> 2) % 8);
    bit  ok = (a < 32) && (i != 7);
    bq.push_back(ok ? 2'b00 : 2'b10);
    if (ok) begin
      for (int k = 0; k < 4; k++) if (s[k]) m[i][k*8 +: 8] = d[k*8 +: 8];
      pidx.push_back(i);
      pval.push_back(m[i]);
    end
    fork
      begin
        if (gap < 0) repeat (-gap) step();
        send_w(d, s);
      end
      begin
        if (gap > 0) repeat (gap) step();
        send_aw(a);
      end
    join
  endtask
  task automatic rd(input logic [31:0] a);
    int n = 0;
    int i = int'((a >> 2) % 8);
    rq.push_back(a >= 32 ? {2'b10, 32'h0} : i == 7 ? {2'b00, reg_hw_d[255:224]} : {2'b00, m[i]});
    axi.araddr = a;
    axi.arvalid = 1'b1;
    @(negedge aclk);
    while (!axi.arready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) flag("ar_timeout");
    step();
    axi.arvalid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0 || pidx.size() != 0 || axi.bvalid || axi.rvalid) && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 300) flag("idle_timeout");
    step();
  endtask
  task automatic check_regs();
    @(negedge aclk);
    for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), 64'(reg_q[i*32 +: 32]), 64'(i == 7 ? 32'h0 : m[i]));
    step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] old3;
    for (int i = 0; i < 7; i++) reg_hw_d[i*32 +: 32] = $urandom;
    reg_hw_d[255:224] = 32'hA5A5A5A5;
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    axi.awaddr = 0; axi.araddr = 0; axi.wdata = 0; axi.wstrb = 0;
    axi.awprot = 0; axi.arprot = 0;
    axi.bready = 1; axi.rready = 1;
    repeat (3) step();
    @(negedge aclk);
    chk("rst_awready", 64'(axi.awready), 0);
    chk("rst_wready", 64'(axi.wready), 0);
    chk("rst_arready", 64'(axi.arready), 0);
    chk("rst_valids", 64'({axi.bvalid, axi.rvalid}), 0);
    chk("rst_resp_data", 64'({axi.bresp, axi.rresp, axi.rdata}), 0);
    chk("rst_regq", 64'(|reg_q), 0);
    chk("rst_pulse", 64'(reg_wr_pulse), 0);
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_ready_low", 64'({axi.awready, axi.wready, axi.arready}), 0);
    @(negedge aclk);
    chk("rel_ready_high", 64'({axi.awready, axi.wready, axi.arready}), 64'h7);
    step();
    wr(32'h04, 32'hDEADBEEF, 4'hF, 0);
    @(negedge aclk);
    chk("lat_full_bvalid", 64'(axi.bvalid), 0);
    chk("lat_full_ready", 64'({axi.awready, axi.wready}), 0);
    @(negedge aclk);
    chk("lat_bvalid", 64'(axi.bvalid), 1);
    step();
    wait_idle();
    fork
      wr(32'h05, 32'h12345678, 4'b0011, 3);
      begin
        step();
        step();
        @(negedge aclk);
        chk("wfirst_wready", 64'(axi.wready), 0);
        chk("wfirst_awready", 64'(axi.awready), 1);
      end
    join
    wait_idle();
    chk("strb_model", 64'(m[1]), 64'h0000_0000_DEAD_5678);
    check_regs();
    wr(32'h1C, 32'h12345678, 4'hF, 0);
    wait_idle();
    check_regs();
    rd(32'h1C);
    wait_idle();
    rd(32'h40);
    wait_idle();
    wr(32'h40, 32'hCAFEF00D, 4'hF, -1);
    wait_idle();
    check_regs();
    axi.bready = 1'b0;
    wr(32'h08, 32'h11111111, 4'hF, 0);
    @(negedge aclk);
    @(negedge aclk);
    chk("bp_bvalid", 64'(axi.bvalid), 1);
    step();
    old3 = m[3];
    wr(32'h0C, 32'h22222222, 4'hF, 0);
    repeat (5) begin
      @(negedge aclk);
      chk("bp_ready", 64'({axi.awready, axi.wready}), 0);
      chk("bp_hold", 64'(axi.bvalid), 1);
      chk("bp_reg3", 64'(reg_q[127:96]), 64'(old3));
    end
    step();
    axi.bready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    chk("bp_b_stays", 64'(axi.bvalid), 1);
    chk("bp_reg3_new", 64'(reg_q[127:96]), 64'h2222_2222);
    step();
    wait_idle();
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    fork
      wr(32'h10, 32'h33333333, 4'hF, 0);
      rd(32'h00);
    join
    begin
      int n = 0;
      while (!(axi.bvalid && axi.rvalid) && n < 20) begin
        @(negedge aclk);
        n++;
      end
      if (n >= 20) flag("rst_setup_timeout");
    end
    step();
    aresetn = 1'b0;
    bq.delete(); rq.delete(); pidx.delete(); pval.delete();
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    @(negedge aclk);
    @(negedge aclk);
    chk("mid_rst_valids", 64'({axi.bvalid, axi.rvalid}), 0);
    chk("mid_rst_ready", 64'({axi.awready, axi.wready, axi.arready}), 0);
    chk("mid_rst_regq", 64'(|reg_q), 0);
    step();
    aresetn = 1'b1;
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    @(negedge aclk);
    chk("mid_rel_low", 64'({axi.awready, axi.wready, axi.arready}), 0);
    @(negedge aclk);
    chk("mid_rel_high", 64'({axi.awready, axi.wready, axi.arready}), 64'h7);
    step();
    rmode = 1'b1;
    repeat (80) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, 31)) : 32'h40 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) < 2) wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
      else rd(a);
      wait_idle();
    end
    rmode = 1'b0;
    step();
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    wait_idle();
    check_regs();
    chk("queues_empty", 64'(bq.size() + rq.size() + pidx.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave register file built on `axi4_lite_if`. It exposes `NREG` bus-addressable registers of `DLEN` bits, with byte strobes, per-register read-only masking and hardware write pulses. AW and W are accepted independently, and errors are reported as SLVERR. It sits between an AXI4-Lite interconnect and peripheral cores (UART control/status and later blocks).

## Interface
- `ALEN`, default 32: address width.
- `DLEN`, default 32: data width, 32 or 64.
- `NREG`, default 8: register count, ≥ 2.
- `RO_MASK`, default `'0`: `NREG` bits; bit i = 1 makes register i read-only from the bus.
- `aclk`  in  1  clock; all logic on the rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `axi`  `axi4_lite_if.S`  bundle  slave port; its `aclk`/`aresetn` are the same nets as above.
- `reg_q`  out  `NREG*DLEN`  RW register contents; register i at `[i*DLEN +: DLEN]`.
- `reg_hw_d`  in  `NREG*DLEN`  read data for RO registers; bits of RW slots are ignored.
- `reg_wr_pulse`  out  `NREG`  one-cycle strobe per register on a successful bus write.

## Operation
- Derived constants:
  - `ADDR_LSB = log2(DLEN/8)`.
  - `IDXW = clog2(NREG)`.
  - index = `addr[ADDR_LSB +: IDXW]`.
  - Address bits below `ADDR_LSB` are ignored.
- Decode error: `addr[ALEN-1:ADDR_LSB+IDXW]` ≠ 0, or index ≥ `NREG`.
- Write path:
  - AW and W each have a one-entry holding buffer.
  - `awready` = AW buffer empty; `wready` = W buffer empty. Either may be captured first, with any gap between them.
  - Commit happens in a cycle where both buffers are full and the B slot is free: `!bvalid || bready`.
  - Commit result:
    - Decode error → no update, bresp SLVERR (2'b10).
    - RO register → no update, SLVERR.
    - Otherwise byte k of register index takes `wdata` byte k where `wstrb[k]`=1, and bresp is OKAY (2'b00).
  - At commit, both buffers are cleared and `bvalid` is set.
  - On a successful commit, `reg_wr_pulse[index]` is high for exactly one cycle, coincident with the first cycle the new value is on `reg_q`. This applies even when `wstrb`=0.
- Read path:
  - Single outstanding read; `arready` = `!rvalid`.
  - On AR handshake, `rdata`/`rresp` are registered:
    - RO slot → `reg_hw_d` slice.
    - RW slot → `reg_q` slice.
    - Decode error → `rdata`=0, rresp SLVERR.
  - `rvalid` stays high and `rdata`/`rresp` stay stable until `rready`.
- Read and write paths are fully independent. A read whose AR handshake coincides with a commit to the same register returns the pre-commit value.
- `awprot`/`arprot` are ignored.

## Timing
- Reset values:
  - `awready`, `wready`, `arready` = 0; each rises in the first cycle after `aresetn` is sampled high.
  - `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata` = 0.
  - `reg_q` = 0, `reg_wr_pulse` = 0.
- Write latency: the later of the AW/W handshakes at edge k → buffers full in cycle k+1 → `bvalid` and new `reg_q` in cycle k+2 (if the B slot is free).
- Write throughput: one write per 2 cycles. Readies drop during the full cycle and return the cycle after commit.
- B backpressure: with `bvalid`=1 and `bready`=0, new AW/W are still captured into the buffers, but commit stalls and readies stay low. A commit is allowed in the same cycle as a B handshake; `bvalid` then stays 1 with the new `bresp`.
- Read latency: `rvalid` in the cycle after the AR handshake. Throughput is one read per 2 cycles; `arready` is low while `rvalid`=1.
- Reset mid-operation: at the next edge with `aresetn`=0, the buffers clear, `bvalid`/`rvalid` drop, `reg_q` goes to 0, and any pending transaction is discarded without a response.
- VALID/READY obey AXI rules: the slave never waits on the master's READY before asserting VALID, and never deasserts VALID without a handshake.

## Structure
- `axi4_lite_pkg`:
  - `resp_e` enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Helper function for `ADDR_LSB` from `DLEN`.
- Sub-module `axi4_lite_hold_buf` (parameter `W`): one-entry valid/ready capture buffer with a `clear` input. Instantiated twice, for AW (`awaddr`) and W (`{wstrb,wdata}`).
- Decode, commit, B and R logic live in the top module.

## Test plan
- Config for all scenarios: `NREG`=8, `DLEN`=32, `RO_MASK`=8'h80.
- AW 0x04 and W 0xDEADBEEF/strb 4'hF in the same cycle, `bready`=1 → `bvalid` 2 cycles later with bresp 00; `reg_q[1]`=0xDEADBEEF; `reg_wr_pulse[1]` one cycle.
- W 0x12345678/strb 4'b0011 three cycles before AW 0x05 on reg1=0xDEADBEEF → reg1=0xDEAD5678, bresp 00.
- Write 0x1C (RO reg 7) → bresp 10, no pulse, `reg_q` unchanged; then read 0x1C with `reg_hw_d[7]`=0xA5A5A5A5 → rdata 0xA5A5A5A5, rresp 00.
- Read 0x40 → rdata 0, rresp 10; write 0x40 → bresp 10, no pulse.
- Hold `bready`=0 for 5 cycles after the first write; a second AW/W is captured, `awready`/`wready` stay 0, and `reg_q` is unchanged. After `bready`=1, the second commit lands in that handshake cycle: `bvalid` stays high with the new response.
- Drop `aresetn` while `bvalid`=1 and `rvalid`=1 → next cycle all valids, readies and `reg_q` are 0; readies return 1 cycle after release.
